// File: rtl/pcpi_issue_ctrl.sv
// pcpi_issue_ctrl: PCPI initiator.
// Takes one command (insn + two operands) at a time, presents it on the
// PCPI request lines until a responder finishes or a watchdog gives up,
// then offers the outcome on a valid/ready response port.
module pcpi_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             resetn,
  // command port
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_insn,
  input  logic [31:0]      cmd_rs1,
  input  logic [31:0]      cmd_rs2,
  // response port
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rd,
  output logic             rsp_wr,
  output logic             rsp_timeout,
  // PCPI request / response
  output logic             pcpi_valid,
  output logic [31:0]      pcpi_insn,
  output logic [31:0]      pcpi_rs1,
  output logic [31:0]      pcpi_rs2,
  input  logic             pcpi_wr,
  input  logic [31:0]      pcpi_rd,
  input  logic             pcpi_wait,
  input  logic             pcpi_ready,
  // status
  output logic             busy,
  output logic [CNT_W-1:0] done_count,
  output logic [CNT_W-1:0] timeout_count
);

  // Watchdog must be able to hold TIMEOUT_CYCLES itself; keep at least 1 bit
  // so the disabled configuration still elaborates.
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0]  WD_LOAD = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             pcpi_valid_q, pcpi_valid_d;
  logic [31:0]      pcpi_insn_q, pcpi_insn_d;
  logic [31:0]      pcpi_rs1_q, pcpi_rs1_d;
  logic [31:0]      pcpi_rs2_q, pcpi_rs2_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rd_q, rsp_rd_d;
  logic             rsp_wr_q, rsp_wr_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] done_count_q, done_count_d;
  logic [CNT_W-1:0] timeout_count_q, timeout_count_d;

  // Next-state and registered-output computation for the issue FSM.
  always_comb begin
    state_d         = state_q;
    wd_d            = wd_q;
    pcpi_valid_d    = pcpi_valid_q;
    pcpi_insn_d     = pcpi_insn_q;
    pcpi_rs1_d      = pcpi_rs1_q;
    pcpi_rs2_d      = pcpi_rs2_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_rd_d        = rsp_rd_q;
    rsp_wr_d        = rsp_wr_q;
    rsp_timeout_d   = rsp_timeout_q;
    done_count_d    = done_count_q;
    timeout_count_d = timeout_count_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          // Operands are captured once here and held for the whole request.
          pcpi_insn_d  = cmd_insn;
          pcpi_rs1_d   = cmd_rs1;
          pcpi_rs2_d   = cmd_rs2;
          pcpi_valid_d = 1'b1;
          wd_d         = WD_LOAD;
          state_d      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (pcpi_ready) begin
          // Completion takes priority over an expiring watchdog. Dropping
          // pcpi_valid on this edge keeps a registered responder from
          // firing a second time.
          pcpi_valid_d  = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rd_d      = pcpi_wr ? pcpi_rd : 32'h0;
          rsp_wr_d      = pcpi_wr;
          rsp_timeout_d = 1'b0;
          if (done_count_q != CNT_MAX) begin
            done_count_d = done_count_q + CNT_ONE;
          end
          state_d = ST_RESP;
        end else if (pcpi_wait) begin
          // A responder has claimed the instruction; restart the watchdog.
          wd_d = WD_LOAD;
        end else if (TIMEOUT_CYCLES != 0) begin
          wd_d = wd_q - WD_ONE;
          if (wd_q == WD_ONE) begin
            pcpi_valid_d  = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rd_d      = 32'h0;
            rsp_wr_d      = 1'b0;
            rsp_timeout_d = 1'b1;
            if (timeout_count_q != CNT_MAX) begin
              timeout_count_d = timeout_count_q + CNT_ONE;
            end
            state_d = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        // Response data stays put until the consumer takes it.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        pcpi_valid_d = 1'b0;
        rsp_valid_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset asserts asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= ST_IDLE;
      wd_q            <= '0;
      pcpi_valid_q    <= 1'b0;
      pcpi_insn_q     <= '0;
      pcpi_rs1_q      <= '0;
      pcpi_rs2_q      <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_rd_q        <= '0;
      rsp_wr_q        <= 1'b0;
      rsp_timeout_q   <= 1'b0;
      busy_q          <= 1'b0;
      done_count_q    <= '0;
      timeout_count_q <= '0;
    end else begin
      state_q         <= state_d;
      wd_q            <= wd_d;
      pcpi_valid_q    <= pcpi_valid_d;
      pcpi_insn_q     <= pcpi_insn_d;
      pcpi_rs1_q      <= pcpi_rs1_d;
      pcpi_rs2_q      <= pcpi_rs2_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rd_q        <= rsp_rd_d;
      rsp_wr_q        <= rsp_wr_d;
      rsp_timeout_q   <= rsp_timeout_d;
      busy_q          <= busy_d;
      done_count_q    <= done_count_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign cmd_ready     = (state_q == ST_IDLE);
  assign pcpi_valid    = pcpi_valid_q;
  assign pcpi_insn     = pcpi_insn_q;
  assign pcpi_rs1      = pcpi_rs1_q;
  assign pcpi_rs2      = pcpi_rs2_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rd        = rsp_rd_q;
  assign rsp_wr        = rsp_wr_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign busy          = busy_q;
  assign done_count    = done_count_q;
  assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_pcpi_issue_ctrl.sv
// Directed bench for pcpi_issue_ctrl: a cycle table for the basic handshakes
// plus hand-written sequences for long ops, watchdog, backpressure and reset.
module tb_pcpi_issue_ctrl;

  logic        clk;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_insn;
  logic [31:0] cmd_rs1;
  logic [31:0] cmd_rs2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rd;
  logic        rsp_wr;
  logic        rsp_timeout;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        busy;
  logic [7:0]  done_count;
  logic [7:0]  timeout_count;

  int n_cmp = 0;
  int n_bad = 0;

  pcpi_issue_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_insn(cmd_insn), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
    .rsp_wr(rsp_wr), .rsp_timeout(rsp_timeout),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .busy(busy), .done_count(done_count), .timeout_count(timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cv;
    logic        rr;
    logic        pw;
    logic        pr;
    logic        pwr;
    logic [31:0] prd;
    logic        e_cr;
    logic        e_pv;
    logic        e_rv;
    logic [31:0] e_rd;
    logic        e_wr;
    logic        e_to;
    logic [7:0]  e_done;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic cv, input logic rr, input logic pw,
                              input logic pr, input logic pwr, input logic [31:0] prd,
                              input logic e_cr, input logic e_pv, input logic e_rv,
                              input logic [31:0] e_rd, input logic e_wr,
                              input logic e_to, input logic [7:0] e_done);
    vec_t v;
    v.cv = cv; v.rr = rr; v.pw = pw; v.pr = pr; v.pwr = pwr; v.prd = prd;
    v.e_cr = e_cr; v.e_pv = e_pv; v.e_rv = e_rv; v.e_rd = e_rd;
    v.e_wr = e_wr; v.e_to = e_to; v.e_done = e_done;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
    cmd_insn  = insn;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  int          cnt;
  logic [7:0]  done_before;
  logic [31:0] held_rd;

  initial begin
    resetn = 1'b0; cmd_valid = 1'b0; cmd_insn = '0; cmd_rs1 = '0; cmd_rs2 = '0;
    rsp_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = '0; pcpi_wait = 1'b0; pcpi_ready = 1'b0;

    // One cycle per row: inputs applied, outputs checked after the edge.
    vecs[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 8'd0);
    vecs[1] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 8'd0);
    vecs[2] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b0, 8'd1);
    vecs[3] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b0, 8'd1);
    vecs[4] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 8'd1);
    vecs[5] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 8'd1);
    vecs[6] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 8'd1);
    vecs[7] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 8'd1);
    vecs[8] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 8'd2);
    vecs[9] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 8'd2);

    // ---- reset state ----
    step(); step();
    check("rst cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst pcpi_valid", 32'(pcpi_valid), 32'd0);
    check("rst pcpi_insn", pcpi_insn, 32'h0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_rd", rsp_rd, 32'h0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done_count", 32'(done_count), 32'd0);
    check("rst timeout_count", 32'(timeout_count), 32'd0);
    resetn = 1'b1;
    step();
    check("post-rst cmd_ready", 32'(cmd_ready), 32'd1);
    check("post-rst pcpi_valid", 32'(pcpi_valid), 32'd0);

    // ---- table: single op with wr, ignored late ready, op without wr ----
    cmd_insn = 32'h0600000B; cmd_rs1 = 32'h05040302; cmd_rs2 = 32'h02020202;
    for (int i = 0; i < 10; i++) begin
      cmd_valid = vecs[i].cv; rsp_ready = vecs[i].rr; pcpi_wait = vecs[i].pw;
      pcpi_ready = vecs[i].pr; pcpi_wr = vecs[i].pwr; pcpi_rd = vecs[i].prd;
      step();
      $display("vec %0d: cmd_ready=%b pcpi_valid=%b rsp_valid=%b rsp_rd=%h done=%0d",
               i, cmd_ready, pcpi_valid, rsp_valid, rsp_rd, done_count);
      check($sformatf("vec%0d cmd_ready", i), 32'(cmd_ready), 32'(vecs[i].e_cr));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(!vecs[i].e_cr));
      check($sformatf("vec%0d pcpi_valid", i), 32'(pcpi_valid), 32'(vecs[i].e_pv));
      check($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rv));
      check($sformatf("vec%0d done_count", i), 32'(done_count), 32'(vecs[i].e_done));
      if (vecs[i].e_pv) begin
        check($sformatf("vec%0d pcpi_insn", i), pcpi_insn, 32'h0600000B);
        check($sformatf("vec%0d pcpi_rs1", i), pcpi_rs1, 32'h05040302);
        check($sformatf("vec%0d pcpi_rs2", i), pcpi_rs2, 32'h02020202);
      end
      if (vecs[i].e_rv) begin
        check($sformatf("vec%0d rsp_rd", i), rsp_rd, vecs[i].e_rd);
        check($sformatf("vec%0d rsp_wr", i), 32'(rsp_wr), 32'(vecs[i].e_wr));
        check($sformatf("vec%0d rsp_timeout", i), 32'(rsp_timeout), 32'(vecs[i].e_to));
      end
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0; pcpi_wait = 1'b0; pcpi_ready = 1'b0; pcpi_wr = 1'b0;

    // ---- long op: 40 wait cycles then ready without wr ----
    accept(32'h0600000B, 32'h1, 32'h2);
    cnt = pcpi_valid ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      pcpi_wait = 1'b1;
      step();
      if (pcpi_valid) cnt++;
    end
    pcpi_wait = 1'b0; pcpi_ready = 1'b1; pcpi_wr = 1'b0; pcpi_rd = 32'hFFFFFFFF;
    step();
    pcpi_ready = 1'b0;
    $display("long op: valid cycles=%0d rsp_valid=%b rsp_timeout=%b rsp_rd=%h", cnt, rsp_valid, rsp_timeout, rsp_rd);
    check("long valid cycles", 32'(cnt), 32'd41);
    check("long pcpi_valid low", 32'(pcpi_valid), 32'd0);
    check("long rsp_valid", 32'(rsp_valid), 32'd1);
    check("long rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("long rsp_rd", rsp_rd, 32'h0);
    check("long rsp_wr", 32'(rsp_wr), 32'd0);
    check("long done_count", 32'(done_count), 32'd3);
    drain();

    // ---- unclaimed instruction: watchdog abort ----
    pcpi_rd = 32'h55AA55AA;
    accept(32'h00000033, 32'h0, 32'h0);
    cnt = pcpi_valid ? 1 : 0;
    for (int i = 0; i < 100 && pcpi_valid; i++) begin
      step();
      if (pcpi_valid) cnt++;
    end
    $display("timeout op: valid cycles=%0d rsp_timeout=%b timeout_count=%0d", cnt, rsp_timeout, timeout_count);
    check("timeout valid cycles", 32'(cnt), 32'd16);
    check("timeout rsp_valid", 32'(rsp_valid), 32'd1);
    check("timeout rsp_timeout", 32'(rsp_timeout), 32'd1);
    check("timeout rsp_rd", rsp_rd, 32'h0);
    check("timeout rsp_wr", 32'(rsp_wr), 32'd0);
    check("timeout timeout_count", 32'(timeout_count), 32'd1);
    check("timeout done_count", 32'(done_count), 32'd3);
    drain();

    // ---- ready on the 16th silent cycle: ready beats the watchdog ----
    accept(32'h0600000B, 32'h3, 32'h4);
    for (int i = 0; i < 15; i++) step();
    check("race valid before ready", 32'(pcpi_valid), 32'd1);
    pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'hA5A5A5A5;
    step();
    pcpi_ready = 1'b0; pcpi_wr = 1'b0;
    $display("race op: rsp_timeout=%b rsp_rd=%h timeout_count=%0d", rsp_timeout, rsp_rd, timeout_count);
    check("race rsp_valid", 32'(rsp_valid), 32'd1);
    check("race rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("race rsp_rd", rsp_rd, 32'hA5A5A5A5);
    check("race timeout_count", 32'(timeout_count), 32'd1);
    check("race done_count", 32'(done_count), 32'd4);
    drain();

    // ---- backpressure with a pending command ----
    cmd_insn = 32'h0600000B; cmd_rs1 = 32'h11; cmd_rs2 = 32'h22; cmd_valid = 1'b1;
    step();
    pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'h0BADF00D;
    step();
    pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = 32'h0;
    held_rd = 32'h0BADF00D;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("bp%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
      check($sformatf("bp%0d rsp_rd", i), rsp_rd, held_rd);
      check($sformatf("bp%0d cmd_ready", i), 32'(cmd_ready), 32'd0);
      check($sformatf("bp%0d pcpi_valid", i), 32'(pcpi_valid), 32'd0);
    end
    $display("backpressure: held rsp_rd=%h over 10 cycles", rsp_rd);
    cmd_insn = 32'h0200000B;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("bp handshake rsp_valid", 32'(rsp_valid), 32'd0);
    check("bp handshake cmd_ready", 32'(cmd_ready), 32'd1);
    check("bp handshake pcpi_valid", 32'(pcpi_valid), 32'd0);
    step();
    cmd_valid = 1'b0;
    $display("backpressure: next accept pcpi_valid=%b pcpi_insn=%h", pcpi_valid, pcpi_insn);
    check("bp next accept pcpi_valid", 32'(pcpi_valid), 32'd1);
    check("bp next accept pcpi_insn", pcpi_insn, 32'h0200000B);
    check("bp next accept cmd_ready", 32'(cmd_ready), 32'd0);
    pcpi_ready = 1'b1;
    step();
    pcpi_ready = 1'b0;
    drain();
    check("bp done_count", 32'(done_count), 32'd6);

    // ---- saturating done counter ----
    for (int i = 0; i < 260; i++) begin
      accept(32'h0600000B, 32'(i), 32'h0);
      pcpi_ready = 1'b1;
      step();
      pcpi_ready = 1'b0;
      drain();
    end
    $display("saturation: done_count=%0d", done_count);
    check("sat done_count", 32'(done_count), 32'd255);
    check("sat timeout_count", 32'(timeout_count), 32'd1);

    // ---- reset while in ISSUE ----
    accept(32'h0600000B, 32'h7, 32'h8);
    step();
    check("pre-reset pcpi_valid", 32'(pcpi_valid), 32'd1);
    resetn = 1'b0;
    #1;
    $display("mid reset: pcpi_valid=%b busy=%b rsp_valid=%b", pcpi_valid, busy, rsp_valid);
    check("midrst pcpi_valid", 32'(pcpi_valid), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst done_count", 32'(done_count), 32'd0);
    check("midrst timeout_count", 32'(timeout_count), 32'd0);
    step(); step();
    resetn = 1'b1;
    step();
    check("after rst cmd_ready", 32'(cmd_ready), 32'd1);
    check("after rst pcpi_valid", 32'(pcpi_valid), 32'd0);
    check("after rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("after rst done_count", 32'(done_count), 32'd0);
    check("after rst timeout_count", 32'(timeout_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pcpi_issue_ctrl.md
Name: pcpi_issue_ctrl

Overview:
- Initiator (master) side of the PCPI coprocessor interface.
- Accepts one command at a time (instruction word plus two operands) on a valid/ready command port and drives pcpi_valid/insn/rs1/rs2 toward any PCPI responder, e.g. the approximate-multiplier coprocessors.
- Returns the result on a valid/ready response port; a responder that never answers is aborted by a watchdog.
- Sits between a test/DMA sequencer or bus-mapped register front-end and the coprocessor array.

Parameters:
- TIMEOUT_CYCLES, 16: max consecutive pcpi_valid cycles with neither pcpi_ready nor pcpi_wait before abort. 0 disables the watchdog.
- CNT_W, 8: width of the saturating status counters.

Ports:
- clk  in  1  clock, all logic on posedge
- resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_insn  in  32  instruction word forwarded to pcpi_insn
- cmd_rs1  in  32  operand 1
- cmd_rs2  in  32  operand 2
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rd  out  32  captured pcpi_rd, or 0 if not written or timed out
- rsp_wr  out  1  responder asserted pcpi_wr with pcpi_ready
- rsp_timeout  out  1  watchdog abort, no responder claimed the instruction
- pcpi_valid  out  1  PCPI request valid
- pcpi_insn  out  32  PCPI instruction
- pcpi_rs1  out  32  PCPI operand 1
- pcpi_rs2  out  32  PCPI operand 2
- pcpi_wr  in  1  responder writes rd
- pcpi_rd  in  32  responder result
- pcpi_wait  in  1  responder claims insn, needs more cycles
- pcpi_ready  in  1  responder done, one-cycle pulse
- busy  out  1  state != IDLE
- done_count  out  CNT_W  completed (ready) transactions, saturating
- timeout_count  out  CNT_W  timed-out transactions, saturating

Behaviour:
- Reset (async assert, sync release): state=IDLE; every output is 0 except cmd_ready=1. This covers pcpi_*, rsp_*, busy and the counters. Reset mid-transaction drops pcpi_valid immediately; no response is produced.
- All outputs are registered except cmd_ready = (state==IDLE).
- IDLE:
  - On cmd_valid && cmd_ready, latch insn/rs1/rs2 onto the pcpi_* outputs.
  - Set pcpi_valid=1 and load the watchdog with TIMEOUT_CYCLES; go to ISSUE.
  - pcpi_valid is therefore high on the cycle after the accept.
- ISSUE (pcpi_valid=1; insn/rs1/rs2 held stable throughout):
  - pcpi_ready=1: capture rsp_rd = pcpi_wr ? pcpi_rd : 0, rsp_wr = pcpi_wr, rsp_timeout=0. Clear pcpi_valid on the same edge, set rsp_valid, increment done_count, go to RESP. pcpi_valid is therefore low the cycle after ready, so a registered responder does not re-fire.
  - Else if pcpi_wait=1: reload the watchdog with TIMEOUT_CYCLES, stay.
  - Else if TIMEOUT_CYCLES!=0: decrement the watchdog. If it was 1, clear pcpi_valid, set rsp_valid with rsp_timeout=1, rsp_rd=0, rsp_wr=0, increment timeout_count, go to RESP. pcpi_valid is thus high for exactly TIMEOUT_CYCLES cycles without ready/wait.
  - pcpi_ready and an expiring watchdog in the same cycle: ready wins, no timeout.
  - pcpi_wr without pcpi_ready is ignored.
- RESP:
  - rsp_valid and the rsp_* data are held until rsp_ready=1; then clear rsp_valid and go to IDLE.
  - rsp_ready sampled while rsp_valid=0 has no effect.
  - Back-to-back commands: the earliest new accept is the cycle after the response handshake.
  - pcpi_ready seen outside ISSUE is ignored.
- Counters stop at 2^CNT_W-1 and clear only on reset.
- Minimum latency: cmd accept at cycle 0 → pcpi_valid at cycle 1. With ready at cycle k, rsp_valid at cycle k+1.

Test Plan:
- Single op, bench responder registered like the multiplier: cmd_insn=0x0600000B, rs1=0x05040302, rs2=0x02020202. Responder returns ready+wr with rd=0x12345678 one cycle after valid. Required: rsp_rd=0x12345678, rsp_wr=1, rsp_timeout=0; pcpi_valid high exactly 2 cycles; done_count=1.
- Long op: responder asserts pcpi_wait for 40 cycles, then ready with wr=0, rd=0xFFFFFFFF. Required: no timeout, rsp_rd=0, rsp_wr=0; pcpi_valid high 41 cycles.
- Unclaimed insn 0x00000033 with no responder activity. Required: pcpi_valid high exactly 16 cycles, then rsp_timeout=1, rsp_rd=0, timeout_count=1.
- Ready on the 16th silent cycle (watchdog expiring). Required: normal completion, rsp_timeout=0, timeout_count unchanged.
- Backpressure: rsp_ready held low for 10 cycles while cmd_valid stays high. Required: rsp data stable, cmd_ready=0 throughout, next accept the cycle after the rsp handshake.
- Reset asserted while in ISSUE. Required: pcpi_valid, busy and rsp_valid at 0 immediately, cmd_ready=1 after release, counters 0.
